// File: rtl/regfile_wb_if.sv
// ============================================================================
// Module      : regfile_wb_if
// Description : Issue/flush/write-back bus between decode and the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_wb_if;
    logic          IssueValid;
    logic          IssueWb;
    logic [4:0]    IssueDst;
    logic          Flush;
    logic [31:0]   WbData;
    logic [1023:0] Regfile_flat;
    logic [31:0]   RdEx;
    logic [31:0]   RdMem;
    logic [31:0]   RdWb;
    logic          WbWrite;
    logic [4:0]    WbDst;
    logic [15:0]   WrCount;

    modport master (
        output IssueValid, IssueWb, IssueDst, Flush, WbData,
        input  Regfile_flat, RdEx, RdMem, RdWb, WbWrite, WbDst, WrCount
    );

    modport slave (
        input  IssueValid, IssueWb, IssueDst, Flush, WbData,
        output Regfile_flat, RdEx, RdMem, RdWb, WbWrite, WbDst, WrCount
    );
endinterface

`default_nettype wire

// File: rtl/regfile_wb.sv
// ============================================================================
// Module      : regfile_wb
// Description : 32x32 register file with EX/MEM/WB pending-write tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb (
    input  wire logic   Clk,
    input  wire logic   Reset,
    regfile_wb_if.slave bus
);
    localparam int          NREGS   = 32;
    localparam int          XLEN    = 32;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic            ex_v_q,   ex_v_d;
    logic [4:0]      ex_dst_q, ex_dst_d;
    logic            mem_v_q,  mem_v_d;
    logic [4:0]      mem_dst_q, mem_dst_d;
    logic            wb_v_q,   wb_v_d;
    logic [4:0]      wb_dst_q, wb_dst_d;
    logic [15:0]     cnt_q,    cnt_d;
    logic [XLEN-1:0] regs_q [NREGS];

    // Flush kills what would enter EX and MEM; the MEM->WB move is never blocked.
    always_comb begin
        ex_v_d    = bus.IssueValid & bus.IssueWb & (bus.IssueDst != 5'd0) & ~bus.Flush;
        ex_dst_d  = bus.IssueDst;
        mem_v_d   = ex_v_q & ~bus.Flush;
        mem_dst_d = ex_dst_q;
        wb_v_d    = mem_v_q;
        wb_dst_d  = mem_dst_q;
        cnt_d     = cnt_q;
        if (wb_v_q && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ex_v_q    <= 1'b0;
            ex_dst_q  <= 5'd0;
            mem_v_q   <= 1'b0;
            mem_dst_q <= 5'd0;
            wb_v_q    <= 1'b0;
            wb_dst_q  <= 5'd0;
            cnt_q     <= 16'd0;
        end else begin
            ex_v_q    <= ex_v_d;
            ex_dst_q  <= ex_dst_d;
            mem_v_q   <= mem_v_d;
            mem_dst_q <= mem_dst_d;
            wb_v_q    <= wb_v_d;
            wb_dst_q  <= wb_dst_d;
            cnt_q     <= cnt_d;
        end
    end

    // A valid entry never carries destination 0, but the guard keeps r0 immune regardless.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_v_q && (wb_dst_q != 5'd0)) begin
            regs_q[wb_dst_q] <= bus.WbData;
        end
    end

    assign bus.RdEx    = ex_v_q  ? (32'd1 << ex_dst_q)  : 32'd0;
    assign bus.RdMem   = mem_v_q ? (32'd1 << mem_dst_q) : 32'd0;
    assign bus.RdWb    = wb_v_q  ? (32'd1 << wb_dst_q)  : 32'd0;
    assign bus.WbWrite = wb_v_q;
    assign bus.WbDst   = wb_v_q ? wb_dst_q : 5'd0;
    assign bus.WrCount = cnt_q;

    generate
        for (genvar i = 0; i < NREGS; i++) begin : g_flat
            assign bus.Regfile_flat[1023-32*i -: 32] = regs_q[i];
        end
    endgenerate
endmodule

`default_nettype wire

// File: doc/regfile_wb.md
REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Reset  input  1  asynchronous, active-low reset.
REQ-003 IssueValid  input  1  decode is latching a real (non-bubble) instruction on this edge.
REQ-004 IssueWb  input  1  the issued instruction writes back a register (decode Control[31]).
REQ-005 IssueDst  input  5  destination register index of the issued instruction.
REQ-006 Flush  input  1  squash the instructions in the EX and MEM stages on this edge.
REQ-007 WbData  input  32  result for the instruction in the WB stage, valid while WbWrite=1.
REQ-008 Regfile_flat  output  1024  architectural registers; register i occupies bits [1023-32*i : 992-32*i], so register 0 is in [1023:992] and register 31 in [31:0].
REQ-009 RdEx, RdMem, RdWb  output  32 each  pending-write bitmaps; bit i set = stage holds a write to register i.
REQ-010 WbWrite  output  1  the WB stage holds a valid write this cycle.
REQ-011 WbDst  output  5  destination index of the WB-stage write; 0 when WbWrite=0.
REQ-012 WrCount  output  16  number of register writes retired since reset.

Function
REQ-013 The block SHALL hold three stage entries (EX, MEM, WB), each a valid bit plus a 5-bit destination.
REQ-014 On each edge, EX SHALL load {IssueValid & IssueWb & (IssueDst!=0), IssueDst}; MEM SHALL load EX; WB SHALL load MEM. Stages advance every cycle; there is no hold or back-pressure.
REQ-015 RdEx/RdMem/RdWb SHALL be the one-hot decode of the matching stage destination when that stage is valid, and all-zero otherwise; bit 0 SHALL never be set.
REQ-016 WbWrite SHALL equal WB.valid, and WbDst SHALL equal WB.dst when valid and 0 otherwise (combinational from the stage register).
REQ-017 On an edge where WbWrite=1, register[WbDst] SHALL take WbData and WrCount SHALL increment, saturating at 16'hFFFF.
REQ-018 Latency: an issue on edge E0 SHALL appear in RdEx after E0, in RdMem after E1 and in RdWb after E2; the register write SHALL occur at E3, so Regfile_flat shows the new value after E3.
REQ-019 Register 0 SHALL read 0 at all times and SHALL never be written.
REQ-020 Flush=1 SHALL invalidate the entries that would be loaded into EX and MEM on that edge; WB SHALL still load from the old MEM entry, so an instruction already past MEM completes.
REQ-021 When Flush and a valid issue occur on the same edge, the flush SHALL win and the issue SHALL be discarded.
REQ-022 Back-to-back issues to the same register SHALL be allowed, and up to three bitmaps may set the same bit simultaneously; the writes SHALL retire in issue order.
REQ-023 Regfile_flat SHALL be driven directly from the register array with no added cycle, so the consumer reads the post-write value on the cycle after E3.

Reset
REQ-024 Asserting Reset low SHALL immediately clear all 32 registers, all stage valid bits and destinations, and WrCount to 0.
REQ-025 While Reset is low, all outputs SHALL be 0.
REQ-026 If Reset is asserted while writes are in flight, those pending writes SHALL be dropped and SHALL NOT occur after Reset is released.
REQ-027 On the first edge after Reset is released, the block SHALL accept an issue normally.

Verification
REQ-028 Issue to register 5 at E0 with WbData=32'hDEADBEEF at E3 -> RdEx=32'h20 after E0, RdMem=32'h20 after E1, RdWb=32'h20 after E2; Regfile_flat[863:832]=DEADBEEF after E3; WrCount=1.
REQ-029 Issue with IssueDst=0, or with IssueWb=0 -> all bitmaps stay 0, WbWrite stays 0, Regfile_flat[1023:992]=0, WrCount unchanged.
REQ-030 Issue to registers 3, 4 and 3 on consecutive edges -> RdEx/RdMem/RdWb = 8/10/8 after the third edge; register 3 finally holds the third instruction's WbData.
REQ-031 Issue to registers 7 and 8 on consecutive edges, then Flush on the next edge while register 7 is in MEM and register 8 is in EX -> register 7 is written, register 8 is not, and RdEx = RdMem = 0 after the flush edge.
REQ-032 Flush on the same edge as an issue to register 9 -> RdEx stays 0 and register 9 is never written.
REQ-033 Assert Reset low while a write to register 12 is in MEM -> all outputs are 0 immediately; no write to register 12 follows Reset release; WrCount=0.
